// File: rtl/top_level_module_pkg.sv
// Shared seven-segment definitions: segment vector type, digit glyphs and the
// fixed all-on / all-off / dash patterns. Bit order is {g,f,e,d,c,b,a}.
package top_level_module_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_D0   = 7'h3F;
    localparam seg_t SEG_D1   = 7'h06;
    localparam seg_t SEG_D2   = 7'h5B;
    localparam seg_t SEG_D3   = 7'h4F;
    localparam seg_t SEG_D4   = 7'h66;
    localparam seg_t SEG_D5   = 7'h6D;
    localparam seg_t SEG_D6   = 7'h7D;
    localparam seg_t SEG_D7   = 7'h07;
    localparam seg_t SEG_D8   = 7'h7F;
    localparam seg_t SEG_D9   = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;
    localparam seg_t ALL_ON   = 7'h7F;
    localparam seg_t ALL_OFF  = 7'h00;

    // Codes above nine are not decimal digits and display as a dash.
    function automatic logic is_valid_bcd(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/top_level_module_bcd_to_seg7.sv
// Purely combinational BCD to active-high segment decoder with an
// invalid-code flag.
module bcd_to_seg7
    import top_level_module_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       pat,
    output logic       invalid
);

    // Glyph lookup; any non-decimal code maps to the dash.
    always_comb begin
        pat = SEG_DASH;
        case (bcd)
            4'd0:    pat = SEG_D0;
            4'd1:    pat = SEG_D1;
            4'd2:    pat = SEG_D2;
            4'd3:    pat = SEG_D3;
            4'd4:    pat = SEG_D4;
            4'd5:    pat = SEG_D5;
            4'd6:    pat = SEG_D6;
            4'd7:    pat = SEG_D7;
            4'd8:    pat = SEG_D8;
            4'd9:    pat = SEG_D9;
            default: pat = SEG_DASH;
        endcase
    end

    // Invalid flag follows the same decimal-range rule as the glyph table.
    always_comb begin
        if (is_valid_bcd(bcd)) begin
            invalid = 1'b0;
        end else begin
            invalid = 1'b1;
        end
    end

endmodule

// File: rtl/top_level_module.sv
// Registered seven-segment driver: lamp-test / blank override mux over a held
// BCD decode, optional output inversion, and the output registers.
module top_level_module
    import top_level_module_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd,
    input  logic       en,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] seg7,
    output logic       err
);

    localparam seg_t RST_SEG = SEG_ACTIVE_LOW ? ~ALL_OFF : ALL_OFF;

    seg_t dec_pat_s;
    logic dec_err_s;
    logic sample_s;
    seg_t next_pat_s;
    seg_t seg_next_s;
    seg_t seg_drive_s;
    logic err_next_s;

    seg_t held_pat_r;
    seg_t seg7_r;
    logic err_r;

    bcd_to_seg7 u_dec (
        .bcd     (bcd),
        .pat     (dec_pat_s),
        .invalid (dec_err_s)
    );

    // A digit is only taken in when enabled and no override is active; the
    // held pattern lets the display return to it once an override clears.
    always_comb begin
        sample_s = en && !lamp_test && !blank;
        if (sample_s) begin
            next_pat_s = dec_pat_s;
            err_next_s = dec_err_s;
        end else begin
            next_pat_s = held_pat_r;
            err_next_s = err_r;
        end
    end

    // Override priority: lamp test beats blank beats the decoded digit.
    always_comb begin
        if (lamp_test) begin
            seg_next_s = ALL_ON;
        end else if (blank) begin
            seg_next_s = ALL_OFF;
        end else begin
            seg_next_s = next_pat_s;
        end
    end

    // Polarity applied just ahead of the output register.
    always_comb begin
        if (SEG_ACTIVE_LOW) begin
            seg_drive_s = ~seg_next_s;
        end else begin
            seg_drive_s = seg_next_s;
        end
    end

    // Output and held-decode registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg7_r     <= RST_SEG;
            err_r      <= 1'b0;
            held_pat_r <= ALL_OFF;
        end else begin
            seg7_r     <= seg_drive_s;
            err_r      <= err_next_s;
            held_pat_r <= next_pat_s;
        end
    end

    assign seg7 = seg7_r;
    assign err  = err_r;

endmodule

// File: tb/tb_top_level_module.sv
// Self-checking bench: both output polarities side by side, directed scenarios
// plus randomized traffic against a behavioural display model.
module tb_top_level_module;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       blank = 1'b0;
    logic       lamp_test = 1'b0;
    logic [3:0] bcd = 4'd0;
    logic [6:0] seg7_h, seg7_l;
    logic       err_h, err_l;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] DIGIT_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model state: last accepted code (-1 = none since reset), its error
    // flag, and the override inputs seen at the last edge.
    int   m_code = -1;
    logic m_err = 1'b0;
    logic m_lamp = 1'b0;
    logic m_blank = 1'b0;

    always #5 clk = ~clk;

    top_level_module #(.SEG_ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .en(en), .blank(blank),
        .lamp_test(lamp_test), .seg7(seg7_h), .err(err_h)
    );

    top_level_module #(.SEG_ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .en(en), .blank(blank),
        .lamp_test(lamp_test), .seg7(seg7_l), .err(err_l)
    );

    function automatic logic [6:0] exp_seg();
        if (m_lamp)           return 7'h7F;
        else if (m_blank)     return 7'h00;
        else if (m_code < 0)  return 7'h00;
        else if (m_code > 9)  return 7'h40;
        else                  return DIGIT_TAB[m_code];
    endfunction

    // Drive early value, switch to the final one before the edge, and let the
    // model see only what is present at the edge.
    task automatic cycle_g(input logic r, input logic e, input logic lt,
                           input logic bl, input logic [3:0] d_early,
                           input logic [3:0] d);
        @(negedge clk);
        rst_n = r; en = e; lamp_test = lt; blank = bl; bcd = d_early;
        #2 bcd = d;
        @(posedge clk);
        if (!r) begin
            m_code = -1; m_err = 1'b0; m_lamp = 1'b0; m_blank = 1'b0;
        end else begin
            m_lamp = lt; m_blank = bl;
            if (e && !lt && !bl) begin
                m_code = int'(d);
                m_err  = (d > 4'd9);
            end
        end
        #1;
    endtask

    task automatic cycle(input logic r, input logic e, input logic lt,
                         input logic bl, input logic [3:0] d);
        cycle_g(r, e, lt, bl, d, d);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            n_cmp++;
            if ({seg7_h, err_h, seg7_l, err_l} !== {7'h00, 1'b0, 7'h7F, 1'b0}) begin
                n_bad++;
                $display("FAIL reset: got h=%h/%b l=%h/%b want h=00/0 l=7f/0",
                         seg7_h, err_h, seg7_l, err_l);
            end
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        n_cmp++;
        if ({seg7_h, err_h} !== {7'h3F, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_release: got %h/%b want 3f/0", seg7_h, err_h);
        end
    endtask

    task automatic test_digits();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'(i));
            n_cmp++;
            if ({seg7_h, err_h, seg7_l} !== {DIGIT_TAB[i], 1'b0, ~DIGIT_TAB[i]}) begin
                n_bad++;
                $display("FAIL digit %0d: got %h/%b l=%h want %h/0 l=%h",
                         i, seg7_h, err_h, seg7_l, DIGIT_TAB[i], ~DIGIT_TAB[i]);
            end
        end
    endtask

    task automatic test_invalid();
        logic [3:0]  codes [3] = '{4'd10, 4'd15, 4'd3};
        logic [6:0]  pats  [3] = '{7'h40, 7'h40, 7'h4F};
        logic        errs  [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, codes[i]);
            n_cmp++;
            if ({seg7_h, err_h, err_l} !== {pats[i], errs[i], errs[i]}) begin
                n_bad++;
                $display("FAIL invalid bcd=%0d: got %h/%b/%b want %h/%b",
                         codes[i], seg7_h, err_h, err_l, pats[i], errs[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic       ens   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       lts   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       bls   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] ds    [5] = '{4'd5, 4'd8, 4'd8, 4'd8, 4'd8};
        logic [6:0] want  [5] = '{7'h6D, 7'h6D, 7'h7F, 7'h00, 7'h6D};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, ens[i], lts[i], bls[i], ds[i]);
            n_cmp++;
            if ({seg7_h, err_h, seg7_l} !== {want[i], 1'b0, ~want[i]}) begin
                n_bad++;
                $display("FAIL hold step %0d: got %h/%b l=%h want %h/0",
                         i, seg7_h, err_h, seg7_l, want[i]);
            end
        end
        // Error flag must survive overrides too.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd12);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
        n_cmp++;
        if ({seg7_h, err_h} !== {7'h7F, 1'b1}) begin
            n_bad++;
            $display("FAIL lamp_keeps_err: got %h/%b want 7f/1", seg7_h, err_h);
        end
    endtask

    task automatic test_active_low();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        n_cmp++;
        if ({seg7_l, err_l} !== {7'h79, 1'b0}) begin
            n_bad++;
            $display("FAIL active_low_one: got %h/%b want 79/0", seg7_l, err_l);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
        n_cmp++;
        if ({seg7_l, seg7_h, err_l} !== {7'h7F, 7'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL active_low_reset: got l=%h h=%h err=%b want 7f 00 0",
                     seg7_l, seg7_h, err_l);
        end
    endtask

    task automatic test_random();
        logic [3:0] d0, d1;
        logic       r, e, lt, bl;
        for (int i = 0; i < 400; i++) begin
            d0 = 4'($urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 24) != 0);
            e  = ($urandom_range(0, 3) != 0);
            lt = ($urandom_range(0, 7) == 0);
            bl = ($urandom_range(0, 6) == 0);
            cycle_g(r, e, lt, bl, d0, d1);
            n_cmp++;
            if ({seg7_h, err_h, seg7_l, err_l} !== {exp_seg(), m_err, ~exp_seg(), m_err}) begin
                n_bad++;
                $display("FAIL random %0d: got h=%h/%b l=%h/%b want %h/%b",
                         i, seg7_h, err_h, seg7_l, err_l, exp_seg(), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_invalid();
        test_hold();
        test_active_low();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/top_level_module.md
TOP_LEVEL_MODULE -- requirements
Module: top_level_module

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 0: when 0 a lit segment is 1; when 1, seg7 is bitwise-inverted at the output register input.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 bcd  input  4  BCD digit to display; valid codes 0-9.
REQ-005 en  input  1  sample enable; when high, the output register loads the new decode on the clock edge.
REQ-006 blank  input  1  forces all segments off.
REQ-007 lamp_test  input  1  forces all segments on.
REQ-008 seg7  output  7  segment drive, bit order {g,f,e,d,c,b,a} (bit 0 = a), registered.
REQ-009 err  output  1  registered flag; high when the last sampled bcd was 10-15.

Function
REQ-010 The block shall decode bcd to the following active-high patterns (hex, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-011 Codes 10-15 shall produce the dash pattern 40 (segment g only) and set err=1; codes 0-9 shall set err=0.
REQ-012 Output priority shall be: rst_n low, then lamp_test (7F, err unchanged), then blank (00, err unchanged), then the normal decode.
REQ-013 seg7 and err shall update exactly one clk edge after bcd, en, blank or lamp_test is sampled: 1-cycle latency, no combinational path from any input to any output.
REQ-014 When en=0, seg7 and err shall hold their current values, except that lamp_test and blank still take effect.
REQ-015 SEG_ACTIVE_LOW=1 shall invert seg7 only; err polarity shall be unaffected.
REQ-016 A change of bcd between clock edges shall have no effect; only the value present at the edge is used.

Reset
REQ-017 While rst_n=0 at a rising edge, seg7 shall load all-off (00 if SEG_ACTIVE_LOW=0, 7F if SEG_ACTIVE_LOW=1) and err shall load 0, regardless of the other inputs.
REQ-018 Reset asserted mid-operation shall take effect at the next edge.
REQ-019 The first edge with rst_n=1 shall load the normal prioritized result.

Structure
REQ-020 A shared package shall hold the ten digit patterns, the dash, ALL_ON (7F) and ALL_OFF (00) constants, and a 7-bit segment typedef.
REQ-021 The combinational decode (bcd to pattern plus invalid flag) shall be a sub-module named bcd_to_seg7.
REQ-022 The top level shall contain only the priority mux, the polarity inversion, and the output registers.

Verification
REQ-023 With rst_n=0 for 2 edges, then rst_n=1, en=1 and bcd=0 -> seg7=00 and err=0 during reset; seg7=3F on the first edge after release.
REQ-024 With en=1 and bcd stepped 0 to 9, one per cycle -> seg7 = 3F,06,5B,4F,66,6D,7D,07,7F,6F, each 1 cycle after its input, with err=0 throughout.
REQ-025 With bcd=10, then 15 -> seg7=40 and err=1; then bcd=3 -> seg7=4F and err=0.
REQ-026 With bcd=5, then en=0 and bcd=8 -> seg7 holds 6D; then lamp_test=1 -> 7F; then blank=1 with lamp_test=0 -> 00; then both cleared -> 6D.
REQ-027 With SEG_ACTIVE_LOW=1 and bcd=1 -> seg7=79; under reset -> seg7=7F.
